ray_pixel_scheduler: RTL and testbench
======================================

# ray_pixel_scheduler

Sequences one frame of primary rays through the raytracer core. Walks pixel coordinates in raster order and issues one single-cycle `core_pixel_valid` pulse per pixel. Waits for the core's shade result and buffers the colour with its coordinates in a small output FIFO drained by a valid/ready consumer (line buffer or display writer). It sits between the frame controller and the `raytracer_top` core, and guarantees that the core only receives a new pixel while idle.

## Interface
Parameters:
- `H_RES`, 320: pixels per line; x counts 0..H_RES-1.
- `V_RES`, 240: lines per frame; y counts 0..V_RES-1.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, ≥2.
- `TIMEOUT_CYCLES`, 255: watchdog limit in WAIT. Used only with `RAY_SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `frame_start`  in  1  starts a frame when sampled high in IDLE.
- `frame_busy`  out  1  high from the frame_start acceptance until frame_done.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `core_pixel_x`  out  10  x coordinate to the core.
- `core_pixel_y`  out  10  y coordinate to the core.
- `core_pixel_valid`  out  1  one-cycle request to the core.
- `core_shade_valid`  in  1  the core's shade result is valid.
- `core_rgb`  in  24  {r,g,b} from the core; sampled with `core_shade_valid`.
- `out_valid`  out  1  the FIFO is not empty.
- `out_ready`  in  1  the consumer accepts the head entry.
- `out_rgb`  out  24  head colour.
- `out_x`  out  10  head x coordinate.
- `out_y`  out  10  head y coordinate.
- `out_last`  out  1  the head entry is the final pixel (H_RES-1, V_RES-1).
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- **IDLE**
  - On `frame_start`: clear x and y to 0, clear `timeout_err`, go to ISSUE.
  - `frame_start` is ignored in every other state.
- **ISSUE**
  - If the FIFO is not full (count < FIFO_DEPTH): assert `core_pixel_valid` for this cycle only and go to WAIT.
  - If the FIFO is full: stall in ISSUE with `core_pixel_valid` low.
- **WAIT**
  - On `core_shade_valid`: push {x, y, last, core_rgb} into the FIFO.
  - If last: go to DRAIN. Otherwise advance x and go to ISSUE.
  - x wraps from H_RES-1 to 0 and increments y.
  - `core_shade_valid` is ignored outside WAIT.
- **DRAIN**
  - When the FIFO is empty: pulse `frame_done`, drop `frame_busy`, go to IDLE.
- `core_pixel_x` and `core_pixel_y` are registered. They are stable from the start of ISSUE through the end of WAIT.
- **FIFO**
  - Pop when `out_valid && out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - A push is never attempted when the FIFO is full, because ISSUE reserved space and no other push path exists.
  - Head outputs are undefined but stable while `out_valid` is low.
- Reset, including mid-frame:
  - FSM goes to IDLE; x, y and the FIFO count are cleared.
  - All outputs are 0: `core_pixel_valid`, `out_valid`, `frame_busy`, `frame_done`, `timeout_err`, coordinates, `out_rgb`, `out_last`.
  - The in-flight core result is discarded.

## Timing
- Edge N samples `frame_start`. During cycle N+1 the FSM is in ISSUE, `frame_busy` is 1, and `core_pixel_valid` is 1 if there is space.
- `core_shade_valid` sampled at edge M: the FIFO entry is visible (`out_valid`=1) in cycle M+1, and the FSM is in ISSUE in cycle M+1.
- Per-pixel cost with `out_ready`=1: 1 ISSUE cycle + core latency (request to `core_shade_valid`) + 0 extra cycles.
- `frame_done` asserts in the cycle after the final pop, or in the cycle after DRAIN is entered if the FIFO is already empty. `frame_busy` is 0 in that same cycle.

## Configuration
- **`RAY_SCHED_TIMEOUT_EN` defined**
  - An 8-bit watchdog counter clears on entry to WAIT and increments each WAIT cycle without `core_shade_valid`.
  - On reaching TIMEOUT_CYCLES, the FSM pushes rgb 0x000020 (background) for the current pixel and sets `timeout_err`.
  - It then advances exactly as a normal result would.
  - A `core_shade_valid` arriving in the same cycle as the timeout wins: the real colour is pushed and no error is flagged.
  - `timeout_err` stays set until the next accepted `frame_start` or reset.
- **Not defined**
  - WAIT waits indefinitely.
  - `timeout_err` is tied to 0 and no counter exists.

## Test plan
- **Basic frame.** H_RES=4, V_RES=2, core model responds 3 cycles after each request with rgb={x,y,0x55}, `out_ready`=1.
  - 8 pops in order (0,0)…(3,1); only the last has `out_last`=1.
  - `frame_done` pulses once; `core_pixel_valid` never repeats for a pixel.
- **Backpressure.** FIFO_DEPTH=2, `out_ready`=0 for 40 cycles, then 1.
  - Exactly 2 requests are issued, then the FSM stalls in ISSUE.
  - After release, all 8 pixels arrive in order with no loss or duplication.
- **Busy start.** Pulse `frame_start` mid-frame.
  - Ignored: coordinates continue and `frame_busy` stays 1.
  - A new `frame_start` after `frame_done` restarts at (0,0).
- **Timeout (macro on).** TIMEOUT_CYCLES=10, core silent for pixel (2,0).
  - That entry has rgb=0x000020, `timeout_err`=1, and the frame completes.
  - `timeout_err` clears on the next `frame_start`.
- **Mid-frame reset.** Assert `rst_n`=0 while in WAIT at pixel (1,1).
  - All outputs go to 0 and `out_valid`=0.
  - A late `core_shade_valid` after reset is ignored.
  - The next frame starts at (0,0).
- **Simultaneous push and pop.** With `out_ready`=1, the FIFO count stays ≤1 throughout the frame.

Source files
------------

// File: rtl/ray_pixel_scheduler.sv
// ray_pixel_scheduler
// Walks one frame of primary rays in raster order, hands each pixel to the
// raytracer core only while the core is idle, and queues the shaded colour
// with its coordinates in a small output FIFO for a downstream consumer.
// Optional feature macro: RAY_SCHED_TIMEOUT_EN adds a WAIT watchdog that
// substitutes a background colour for a silent core and sets timeout_err.
//
// Handshakes:
//   core side  : core_pixel_valid is a one-cycle request. The core answers
//                with a one-cycle core_shade_valid (core_rgb alongside). The
//                answer is only taken in WAIT.
//   output side: valid/ready. An entry transfers on a cycle where
//                out_valid && out_ready. out_valid never drops without a
//                transfer, and head fields hold while out_valid is high.
module ray_pixel_scheduler #(
  parameter int H_RES          = 320,
  parameter int V_RES          = 240,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [9:0]  core_pixel_x,
  output logic [9:0]  core_pixel_y,
  output logic        core_pixel_valid,
  input  logic        core_shade_valid,
  input  logic [23:0] core_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_rgb,
  output logic [9:0]  out_x,
  output logic [9:0]  out_y,
  output logic        out_last,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [9:0]       X_MAX    = 10'(H_RES - 1);
  localparam logic [9:0]       Y_MAX    = 10'(V_RES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [23:0]      BG_RGB   = 24'h000020;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        last;
    logic [23:0] rgb;
  } entry_t;

  state_e           state_q, state_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic             terr_q, terr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];

  logic   result_ok;
  logic   timed_out;
  logic   push;
  logic   pop;
  logic   is_last;
  entry_t push_entry;

`ifdef RAY_SCHED_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdog_q, wdog_d;
`endif

  // Detect the end of WAIT: a real shade result, or (optionally) the watchdog
  always_comb begin
    result_ok = (state_q == S_WAIT) && core_shade_valid;
`ifdef RAY_SCHED_TIMEOUT_EN
    // The watchdog fires on the TIMEOUT_CYCLES-th silent WAIT cycle; a real
    // result in that same cycle takes priority.
    timed_out = (state_q == S_WAIT) && !core_shade_valid && (wdog_q == TO_LAST);
    wdog_d    = wdog_q;
    if (state_q == S_ISSUE) begin
      wdog_d = '0;
    end else if ((state_q == S_WAIT) && !core_shade_valid && !timed_out) begin
      wdog_d = wdog_q + 8'd1;
    end
`else
    timed_out = 1'b0;
`endif
  end

  // Output FIFO bookkeeping: ISSUE only leaves when space was reserved, so a
  // push never meets a full FIFO
  always_comb begin
    is_last         = (x_q == X_MAX) && (y_q == Y_MAX);
    push            = result_ok || timed_out;
    pop             = out_valid && out_ready;
    push_entry.x    = x_q;
    push_entry.y    = y_q;
    push_entry.last = is_last;
    push_entry.rgb  = timed_out ? BG_RGB : core_rgb;
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Frame sequencing: next state, raster position and registered outputs
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          x_d     = '0;
          y_d     = '0;
          terr_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // req_q is high exactly when this ISSUE cycle had FIFO space
        if (req_q) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (push) begin
          if (timed_out) begin
            terr_d = 1'b1;
          end
          if (is_last) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
            if (x_q == X_MAX) begin
              x_d = '0;
              y_d = y_q + 10'd1;
            end else begin
              x_d = x_q + 10'd1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Request the pixel in the first ISSUE cycle that sees a free slot
    req_d = (state_d == S_ISSUE) && (count_d != CNT_FULL);
  end

  // Controller and FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      terr_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      req_q    <= req_d;
      terr_q   <= terr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

`ifdef RAY_SCHED_TIMEOUT_EN
  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  assign frame_busy       = busy_q;
  assign frame_done       = done_q;
  assign core_pixel_x     = x_q;
  assign core_pixel_y     = y_q;
  assign core_pixel_valid = req_q;
  assign timeout_err      = terr_q;
  assign out_valid        = (count_q != '0);
  assign out_rgb          = mem_q[rd_ptr_q].rgb;
  assign out_x            = mem_q[rd_ptr_q].x;
  assign out_y            = mem_q[rd_ptr_q].y;
  assign out_last         = mem_q[rd_ptr_q].last;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
// tb_ray_pixel_scheduler
// Drives a small 4x2 frame through ray_pixel_scheduler with a modelled core,
// and checks every cycle against a queue-based model of the frame rules.
module tb_ray_pixel_scheduler;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int DEPTH = 2;
  localparam int TO    = 10;
  localparam int NPIX  = H * V;
  localparam int EW    = 45;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_busy, frame_done;
  logic [9:0]  core_pixel_x, core_pixel_y;
  logic        core_pixel_valid;
  logic        core_shade_valid;
  logic [23:0] core_rgb;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic [9:0]  out_x, out_y;
  logic        out_last;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  ray_pixel_scheduler #(
    .H_RES(H), .V_RES(V), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .core_pixel_x(core_pixel_x), .core_pixel_y(core_pixel_y),
    .core_pixel_valid(core_pixel_valid),
    .core_shade_valid(core_shade_valid), .core_rgb(core_rgb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rgb(out_rgb), .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs shared by the driver processes
  bit ready_mode = 0;
  bit ready_val  = 1;
  bit lat_rand   = 0;
  int lat_fix    = 3;
  bit silent_en  = 0;
  bit spur_en    = 0;
  bit rgb_mode   = 1;

  // Scenario counters sampled from DUT outputs
  int req_count, pop_count, last_count, done_count, max_cnt;
  logic [23:0] pop_rgb_at [NPIX];

  task automatic clear_counters();
    req_count = 0; pop_count = 0; last_count = 0; done_count = 0; max_cnt = 0;
    for (int i = 0; i < NPIX; i++) pop_rgb_at[i] = 24'hxxxxxx;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!frame_done && n < budget) begin
      tick();
      n++;
    end
    chk(name, frame_done, 1'b1);
  endtask

  // Core model: answers each request after a latency with a colour
  initial begin : core_model
    bit          pend;
    int          cnt;
    logic [23:0] pend_rgb;
    pend = 0; cnt = 0; pend_rgb = '0;
    core_shade_valid = 1'b0;
    core_rgb = '0;
    forever begin
      tick();
      core_shade_valid = 1'b0;
      core_rgb = 24'($urandom);
      if (spur_en && $urandom_range(0, 19) == 0) core_shade_valid = 1'b1;
      if (pend) begin
        if (cnt == 0) begin
          core_shade_valid = 1'b1;
          core_rgb = pend_rgb;
          pend = 0;
        end else begin
          cnt--;
        end
      end
      if (core_pixel_valid) begin
        if (!(silent_en && core_pixel_x == 10'd2 && core_pixel_y == 10'd0)) begin
          pend = 1;
          cnt = (lat_rand ? $urandom_range(1, 5) : lat_fix) - 1;
          pend_rgb = rgb_mode ? {core_pixel_x[7:0], core_pixel_y[7:0], 8'h55} : 24'($urandom);
        end
      end
    end
  end

  // Consumer: fixed or random ready
  initial begin : consumer
    out_ready = 1'b1;
    forever begin
      tick();
      out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_val;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef enum int {M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_DRAIN = 3} mphase_e;
  mphase_e       m_state = M_IDLE;
  int            m_idx = 0;
  int            m_wcnt = 0;
  bit            m_busy = 0, m_done = 0, m_terr = 0;
  logic [EW-1:0] exp_q [$];

  always @(negedge clk) begin : compare
    int          s0;
    bit          got, fire, last;
    logic [23:0] rgb;
    logic [9:0]  mx, my;
    if (!rst_n) begin
      chk("rst_pixel_valid", core_pixel_valid, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", frame_busy, 1'b0);
      chk("rst_done", frame_done, 1'b0);
      chk("rst_timeout_err", timeout_err, 1'b0);
      chk("rst_coords", {core_pixel_x, core_pixel_y}, 20'd0);
      chk("rst_out_rgb", out_rgb, 24'd0);
      chk("rst_out_last", out_last, 1'b0);
      exp_q.delete();
      m_state = M_IDLE; m_idx = 0; m_wcnt = 0;
      m_busy = 0; m_done = 0; m_terr = 0;
    end else begin
      s0 = exp_q.size();
      mx = 10'(m_idx % H);
      my = 10'(m_idx / H);
      chk("out_valid", out_valid, s0 != 0);
      if (s0 != 0) chk("head_entry", {out_x, out_y, out_last, out_rgb}, exp_q[0]);
      chk("frame_busy", frame_busy, m_busy);
      chk("frame_done", frame_done, m_done);
      chk("timeout_err", timeout_err, m_terr);
      chk("pixel_valid", core_pixel_valid, (m_state == M_ISSUE) && (s0 < DEPTH));
      chk("state", dbg_state, 64'(int'(m_state)));
      if (m_state != M_IDLE) begin
        chk("pixel_x", core_pixel_x, mx);
        chk("pixel_y", core_pixel_y, my);
      end
      if (core_pixel_valid) req_count++;
      if (frame_done) done_count++;
      if (out_valid && out_ready) begin
        pop_count++;
        if (out_last) last_count++;
        pop_rgb_at[(int'(out_y) * H + int'(out_x)) % NPIX] = out_rgb;
      end
      // advance the model across the coming clock edge
      if (s0 != 0 && out_ready) void'(exp_q.pop_front());
      m_done = 0;
      case (m_state)
        M_IDLE: begin
          if (frame_start) begin
            m_state = M_ISSUE; m_idx = 0; m_busy = 1; m_terr = 0;
          end
        end
        M_ISSUE: begin
          if (s0 < DEPTH) begin
            m_state = M_WAIT;
            m_wcnt = 0;
          end
        end
        M_WAIT: begin
          got = core_shade_valid;
          fire = 0;
          rgb = core_rgb;
`ifdef RAY_SCHED_TIMEOUT_EN
          if (!got) begin
            if (m_wcnt == TO - 1) begin
              fire = 1;
              rgb = 24'h000020;
              m_terr = 1;
            end else begin
              m_wcnt++;
            end
          end
`endif
          if (got || fire) begin
            last = (m_idx == NPIX - 1);
            exp_q.push_back({mx, my, last, rgb});
            if (last) begin
              m_state = M_DRAIN;
            end else begin
              m_idx++;
              m_state = M_ISSUE;
            end
          end
        end
        M_DRAIN: begin
          if (exp_q.size() == 0) begin
            m_state = M_IDLE; m_busy = 0; m_done = 1;
          end
        end
        default: m_state = M_IDLE;
      endcase
      if (exp_q.size() > max_cnt) max_cnt = exp_q.size();
    end
  end

  // Absolute bound on run time
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin : tests
    int n;
    bit found;
    clear_counters();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic frame: latency 3, consumer always ready
    clear_counters();
    start_frame();
    chk("t1_first_req", core_pixel_valid, 1'b1);
    n = 0;
    while (!frame_done && n < 500) begin
      tick();
      n++;
    end
    chk("t1_done_cycle", n, 33);
    repeat (2) tick();
    chk("t1_req_count", req_count, 8);
    chk("t1_pop_count", pop_count, 8);
    chk("t1_last_count", last_count, 1);
    chk("t1_done_count", done_count, 1);
    chk("t1_rgb_first", pop_rgb_at[0], 24'h000055);
    chk("t1_rgb_last", pop_rgb_at[7], 24'h030155);
    chk("t1_max_count_le1", max_cnt <= 1, 1'b1);

    // Backpressure: consumer stalled for 40 cycles
    ready_val = 0;
    tick();
    clear_counters();
    start_frame();
    repeat (40) tick();
    chk("t2_req_count_stalled", req_count, 2);
    chk("t2_stall_in_issue", dbg_state, 2'd1);
    chk("t2_out_valid_held", out_valid, 1'b1);
    ready_val = 1;
    wait_done(1000, "t2_done");
    tick();
    chk("t2_pop_count", pop_count, 8);
    chk("t2_req_count", req_count, 8);
    chk("t2_last_count", last_count, 1);

    // Busy start: frame_start pulses mid-frame are ignored
    clear_counters();
    start_frame();
    repeat (10) tick();
    start_frame();
    chk("t3_busy_kept", frame_busy, 1'b1);
    repeat (3) tick();
    start_frame();
    wait_done(1000, "t3_done");
    tick();
    chk("t3_req_count", req_count, 8);
    chk("t3_done_count", done_count, 1);
    chk("t3_pop_count", pop_count, 8);
    start_frame();
    chk("t3_restart_req", core_pixel_valid, 1'b1);
    chk("t3_restart_xy", {core_pixel_x, core_pixel_y}, 20'd0);
    wait_done(1000, "t3_restart_done");
    tick();

`ifdef RAY_SCHED_TIMEOUT_EN
    // Timeout: core stays silent for pixel (2,0)
    silent_en = 1;
    lat_fix = 2;
    clear_counters();
    start_frame();
    wait_done(1000, "t4_done");
    tick();
    chk("t4_timeout_err_set", timeout_err, 1'b1);
    chk("t4_bg_rgb", pop_rgb_at[2], 24'h000020);
    chk("t4_pop_count", pop_count, 8);
    silent_en = 0;
    start_frame();
    tick();
    chk("t4_timeout_err_clear", timeout_err, 1'b0);
    wait_done(1000, "t4_done2");
    tick();
`else
    // Without the watchdog the flag never rises
    chk("t4_timeout_err_tied", timeout_err, 1'b0);
`endif

    // Mid-frame reset while waiting on pixel (1,1)
    lat_fix = 4;
    start_frame();
    found = 0;
    n = 0;
    while (!found && n < 300) begin
      if (core_pixel_valid && core_pixel_x == 10'd1 && core_pixel_y == 10'd1) found = 1;
      else begin
        tick();
        n++;
      end
    end
    chk("t5_reached_1_1", found, 1'b1);
    tick();
    rst_n = 1'b0;
    #2;
    chk("t5_rst_out_valid", out_valid, 1'b0);
    chk("t5_rst_busy", frame_busy, 1'b0);
    chk("t5_rst_xy", {core_pixel_x, core_pixel_y}, 20'd0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("t5_late_shade_ignored", out_valid, 1'b0);
    chk("t5_idle_after_reset", frame_busy, 1'b0);
    start_frame();
    chk("t5_restart_xy", {core_pixel_x, core_pixel_y}, 20'd0);
    wait_done(1000, "t5_done");
    tick();

    // Randomized traffic: random latency, ready, stray pulses
    rgb_mode = 0;
    lat_rand = 1;
    ready_mode = 1;
    spur_en = 1;
    repeat (1500) begin
      frame_start = ($urandom_range(0, 7) == 0);
      tick();
    end
    frame_start = 1'b0;
    spur_en = 0;
    n = 0;
    while (frame_busy && n < 2000) begin
      tick();
      n++;
    end
    chk("t6_quiesce", frame_busy, 1'b0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
